// File: rtl/dispatch_stage.sv
// dispatch_stage: in-order uop FIFO dispatching the head to ROB and ALU/branch/memory queues with source-ready bits
package dispatch_pkg;
  localparam int PREG_W = 7;
  typedef struct packed {
    logic [15:0]       tag;
    logic              fu_alu;
    logic              fu_br;
    logic              fu_mem;
    logic [PREG_W-1:0] pd_new;
    logic [PREG_W-1:0] ps1;
    logic [PREG_W-1:0] ps2;
  } rename_data;
endpackage

module dispatch_stage #(
  parameter int DEPTH  = 4,
  parameter int NPREG  = 128,
  parameter int PREG_W = dispatch_pkg::PREG_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  dispatch_pkg::rename_data in_data,
  output logic                     in_ready,
  input  logic                     rob_ready,
  output logic                     rob_alloc,
  output dispatch_pkg::rename_data disp_data,
  output logic                     ps1_rdy,
  output logic                     ps2_rdy,
  output logic                     alu_valid,
  input  logic                     alu_ready,
  output logic                     br_valid,
  input  logic                     br_ready,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  input  logic                     wb_valid,
  input  logic [PREG_W-1:0]        wb_preg,
  input  logic                     mispredict
);
  localparam int AW = $clog2(DEPTH);
  dispatch_pkg::rename_data mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [AW:0]      count;
  logic [NPREG-1:0] busy;
  logic             push, fire, offer;
  assign in_ready  = count < (AW+1)'(DEPTH);
  assign push      = in_valid && in_ready && !mispredict;
  assign disp_data = mem[rd_ptr];
  assign offer     = (count != '0) && rob_ready && !mispredict;
  assign br_valid  = offer && disp_data.fu_br;
  assign mem_valid = offer && !disp_data.fu_br && disp_data.fu_mem;
  assign alu_valid = offer && !disp_data.fu_br && !disp_data.fu_mem;
  assign fire      = (br_valid && br_ready) || (mem_valid && mem_ready) || (alu_valid && alu_ready);
  assign rob_alloc = fire;
  assign ps1_rdy   = (disp_data.ps1 == '0) || !busy[disp_data.ps1] || (wb_valid && wb_preg == disp_data.ps1);
  assign ps2_rdy   = (disp_data.ps2 == '0) || !busy[disp_data.ps2] || (wb_valid && wb_preg == disp_data.ps2);
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= in_data;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= mispredict ? '0 : rd_ptr + AW'(fire);
      wr_ptr <= mispredict ? '0 : wr_ptr + AW'(push);
      count  <= mispredict ? '0 : count + (AW+1)'(push) - (AW+1)'(fire);
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) busy <= '0;
    else begin
      if (wb_valid) busy[wb_preg] <= 1'b0;
      if (fire && disp_data.pd_new != '0) busy[disp_data.pd_new] <= 1'b1;
    end
endmodule

// File: tb/tb_dispatch_stage.sv
// tb_dispatch_stage: directed scoreboard bench for dispatch_stage
module tb_dispatch_stage;
  import dispatch_pkg::*;
  logic clk = 0, reset = 1;
  logic in_valid = 0, rob_ready = 0, alu_ready = 0, br_ready = 0, mem_ready = 0;
  logic wb_valid = 0, mispredict = 0;
  logic [6:0] wb_preg = '0;
  rename_data in_data = '0, disp_data;
  logic in_ready, rob_alloc, ps1_rdy, ps2_rdy, alu_valid, br_valid, mem_valid;
  rename_data q[$];
  logic [127:0] busy_m = '0;
  logic pend = 0;
  logic [6:0] pend_p = '0;
  int n_assert = 0, n_fail = 0;

  dispatch_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .rob_ready(rob_ready), .rob_alloc(rob_alloc), .disp_data(disp_data),
    .ps1_rdy(ps1_rdy), .ps2_rdy(ps2_rdy),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .br_valid(br_valid), .br_ready(br_ready),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .wb_valid(wb_valid), .wb_preg(wb_preg), .mispredict(mispredict)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  function automatic rename_data mk(input int tag, input bit a, input bit b, input bit m,
                                    input int pd, input int s1, input int s2);
    rename_data d;
    d.tag = 16'(tag); d.fu_alu = a; d.fu_br = b; d.fu_mem = m;
    d.pd_new = 7'(pd); d.ps1 = 7'(s1); d.ps2 = 7'(s2);
    return d;
  endfunction

  function automatic bit rdy_m(input logic [6:0] p);
    return p == 0 || !busy_m[p] || (wb_valid && wb_preg == p);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    if (wb_valid) busy_m[wb_preg] = 1'b0;
    if (pend) busy_m[pend_p] = 1'b1;
    pend = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic expect_disp(input string tag, input int lane, input bit fire);
    chk({tag, ".alu_valid"}, 64'(alu_valid), 64'(lane == 1));
    chk({tag, ".br_valid"},  64'(br_valid),  64'(lane == 2));
    chk({tag, ".mem_valid"}, 64'(mem_valid), 64'(lane == 3));
    chk({tag, ".rob_alloc"}, 64'(rob_alloc), 64'(fire));
    if (lane != 0) begin
      if (q.size() == 0) chk({tag, ".sb_empty"}, 64'(lane), 64'(0));
      else begin
        chk({tag, ".disp_data"}, 64'(disp_data), 64'(q[0]));
        chk({tag, ".ps1_rdy"}, 64'(ps1_rdy), 64'(rdy_m(q[0].ps1)));
        chk({tag, ".ps2_rdy"}, 64'(ps2_rdy), 64'(rdy_m(q[0].ps2)));
        if (fire) begin
          if (q[0].pd_new != 0) begin pend = 1; pend_p = q[0].pd_new; end
          void'(q.pop_front());
        end
      end
    end
  endtask

  initial begin
    rename_data d;
    // reset state
    tick(); tick();
    chk("rst.in_ready", 64'(in_ready), 64'(1));
    expect_disp("rst", 0, 0);
    reset = 0;
    tick();
    // 1: single ALU uop
    rob_ready = 1; alu_ready = 1;
    d = mk(1, 1, 0, 0, 33, 5, 0); in_valid = 1; in_data = d; settle();
    chk("t1.in_ready", 64'(in_ready), 64'(1));
    expect_disp("t1.pre", 0, 0);
    q.push_back(d); tick();
    in_valid = 0; settle();
    expect_disp("t1.fire", 1, 1);
    tick(); settle();
    expect_disp("t1.empty", 0, 0);
    // 2: fill with lanes blocked, then drain in order
    alu_ready = 0; br_ready = 0; mem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: d = mk(20, 1, 0, 0, 50, 1, 2);
        1: d = mk(21, 0, 0, 1, 51, 3, 4);
        2: d = mk(22, 0, 1, 0, 52, 6, 7);
        default: d = mk(23, 0, 0, 0, 53, 8, 9);
      endcase
      in_valid = 1; in_data = d; settle();
      chk("t2.fill_in_ready", 64'(in_ready), 64'(1));
      expect_disp("t2.fill", i == 0 ? 0 : 1, 0);
      q.push_back(d); tick();
    end
    in_valid = 1; in_data = mk(99, 1, 0, 0, 60, 0, 0); settle();
    chk("t2.full_in_ready", 64'(in_ready), 64'(0));
    expect_disp("t2.full", 1, 0);
    tick();
    in_valid = 0; alu_ready = 1; br_ready = 1; mem_ready = 1; settle();
    expect_disp("t2.drain0", 1, 1); tick();
    chk("t2.in_ready_after_pop", 64'(in_ready), 64'(1));
    expect_disp("t2.drain1", 3, 1); tick();
    expect_disp("t2.drain2", 2, 1); tick();
    expect_disp("t2.drain3", 1, 1); tick();
    expect_disp("t2.drained", 0, 0);
    // 3: fu_br and fu_mem both set -> branch lane; rob_ready holds head
    rob_ready = 0; br_ready = 0;
    d = mk(30, 0, 1, 1, 0, 0, 0); in_valid = 1; in_data = d; settle();
    q.push_back(d); tick();
    in_valid = 0; settle();
    expect_disp("t3.rob_block", 0, 0);
    chk("t3.head_held", 64'(disp_data), 64'(d));
    tick();
    rob_ready = 1; settle();
    expect_disp("t3.offer", 2, 0); tick();
    br_ready = 1; settle();
    expect_disp("t3.fire", 2, 1); tick();
    // 4: writeback bypass of busy source
    alu_ready = 0;
    d = mk(40, 1, 0, 0, 0, 33, 0); in_valid = 1; in_data = d; settle();
    q.push_back(d); tick();
    in_valid = 0; settle();
    chk("t4.ps1_busy", 64'(ps1_rdy), 64'(0));
    expect_disp("t4.wait", 1, 0); tick();
    alu_ready = 1; wb_valid = 1; wb_preg = 33; settle();
    chk("t4.ps1_bypass", 64'(ps1_rdy), 64'(1));
    expect_disp("t4.fire", 1, 1); tick();
    wb_valid = 0;
    d = mk(41, 1, 0, 0, 0, 33, 33); in_valid = 1; in_data = d; settle();
    q.push_back(d); tick();
    in_valid = 0; settle();
    chk("t4.ps1_cleared", 64'(ps1_rdy), 64'(1));
    expect_disp("t4.fire2", 1, 1); tick();
    // 5: set beats same-cycle clear
    d = mk(50, 1, 0, 0, 40, 0, 0); in_valid = 1; in_data = d; settle();
    q.push_back(d); tick();
    in_valid = 0; wb_valid = 1; wb_preg = 40; settle();
    expect_disp("t5.fire", 1, 1); tick();
    wb_valid = 0; alu_ready = 0;
    d = mk(51, 1, 0, 0, 0, 40, 40); in_valid = 1; in_data = d; settle();
    q.push_back(d); tick();
    in_valid = 0; settle();
    chk("t5.ps1_busy40", 64'(ps1_rdy), 64'(0));
    chk("t5.ps2_busy40", 64'(ps2_rdy), 64'(0));
    expect_disp("t5.hold", 1, 0); tick();
    alu_ready = 1; settle();
    expect_disp("t5.drain", 1, 1); tick();
    // 6: mispredict flushes buffered uops and drops same-cycle push
    alu_ready = 0; br_ready = 0; mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      d = mk(60 + i, 0, i == 1, i == 2, 70 + i, 0, 0); in_valid = 1; in_data = d; settle();
      q.push_back(d); tick();
    end
    alu_ready = 1; br_ready = 1; mem_ready = 1; mispredict = 1;
    in_data = mk(69, 1, 0, 0, 79, 0, 0); settle();
    expect_disp("t6.flush", 0, 0);
    q.delete(); tick();
    mispredict = 0; in_valid = 0; settle();
    chk("t6.in_ready", 64'(in_ready), 64'(1));
    expect_disp("t6.empty", 0, 0); tick();
    expect_disp("t6.empty2", 0, 0);
    alu_ready = 0; br_ready = 0; mem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      d = mk(80 + i, 1, 0, 0, 0, 0, 0); in_valid = 1; in_data = d; settle();
      expect_disp("t6.refill", i == 0 ? 0 : 1, 0);
      q.push_back(d); tick();
    end
    in_valid = 0; settle();
    chk("t6.refill_full", 64'(in_ready), 64'(0));
    // asynchronous reset mid-operation
    #2 reset = 1; #1;
    chk("rst2.in_ready", 64'(in_ready), 64'(1));
    chk("rst2.alu_valid", 64'(alu_valid), 64'(0));
    q.delete(); busy_m = '0; pend = 0;
    tick(); reset = 0; tick();
    alu_ready = 1;
    d = mk(90, 1, 0, 0, 0, 40, 0); in_valid = 1; in_data = d; settle();
    q.push_back(d); tick();
    in_valid = 0; settle();
    chk("rst2.busy_cleared", 64'(ps1_rdy), 64'(1));
    expect_disp("rst2.fire", 1, 1); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
